ica_ram_sequencer: RTL and testbench

- Sequences the shared sample RAM between the whitening stage (producer) and the FastICA stage (consumer).
- Fill phase: writes N_SAMPLES whitened 4-channel vectors into RAM.
- Read phase: replays the whole buffer to FastICA once per iteration pass until FastICA reports convergence or MAX_PASSES is reached.
- Drives the RAM read/write select and address, and the go strobes for both datapath blocks.

---
 rtl/ica_ram_sequencer_if.sv | 54 +++++
 rtl/ica_ram_sequencer.sv | 127 ++++++++++++
 tb/tb_ica_ram_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ica_ram_sequencer_if.sv
// Sequencer bus: start/handshake strobes, RAM control and pass status.
// slave = sequencer side, master = environment (datapath/RAM/test) side.
interface ica_ram_sequencer_if #(
  parameter int ADDR_W = 14
);
  logic              go;
  logic              whiten_valid;
  logic              ica_next;
  logic              ica_converged;
  logic              go_whitening;
  logic              go_fastica;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic              z_valid;
  logic              z_last;
  logic [7:0]        pass_idx;
  logic              busy;
  logic              done;
  logic              timeout;

  modport slave (
    input  go,
    input  whiten_valid,
    input  ica_next,
    input  ica_converged,
    output go_whitening,
    output go_fastica,
    output mem_rw,
    output mem_addr,
    output z_valid,
    output z_last,
    output pass_idx,
    output busy,
    output done,
    output timeout
  );

  modport master (
    output go,
    output whiten_valid,
    output ica_next,
    output ica_converged,
    input  go_whitening,
    input  go_fastica,
    input  mem_rw,
    input  mem_addr,
    input  z_valid,
    input  z_last,
    input  pass_idx,
    input  busy,
    input  done,
    input  timeout
  );
endinterface

// File: rtl/ica_ram_sequencer.sv
// Shared sample RAM sequencer: fills from whitening, then replays the
// buffer to FastICA once per pass until convergence or the pass limit.
module ica_ram_sequencer #(
  parameter int ADDR_W     = 14,
  parameter int N_SAMPLES  = 10000,
  parameter int MAX_PASSES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ica_ram_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_READ = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Terminal compare keeps the counter in range even at N == 2**ADDR_W
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
  localparam logic [7:0]        LAST_PASS = 8'(MAX_PASSES - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_pass;
  logic              r_gow;
  logic              r_gof;
  logic              r_zv;
  logic              r_zl;
  logic              r_timeout;

  logic              w_rd;
  logic              w_at_last;

  assign w_rd      = (r_state == S_READ);
  assign w_at_last = (r_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_pass    <= '0;
      r_gow     <= 1'b0;
      r_gof     <= 1'b0;
      r_zv      <= 1'b0;
      r_zl      <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_gow <= 1'b0;
      r_gof <= 1'b0;
      // One-cycle RAM read latency
      r_zv  <= w_rd;
      r_zl  <= w_rd && w_at_last;
      unique case (r_state)
        S_IDLE: begin
          if (bus.go) begin
            r_state <= S_FILL;
            r_addr  <= '0;
            r_gow   <= 1'b1;
          end
        end
        S_FILL: begin
          if (bus.whiten_valid) begin
            if (w_at_last) begin
              r_state <= S_READ;
              r_addr  <= '0;
              r_pass  <= '0;
              r_gof   <= 1'b1;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        S_READ: begin
          if (w_at_last) begin
            r_state <= S_WAIT;
            r_addr  <= '0;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        S_WAIT: begin
          if (bus.ica_converged) begin
            r_state   <= S_DONE;
            r_timeout <= 1'b0;
          end else if (bus.ica_next) begin
            if (r_pass == LAST_PASS) begin
              r_state   <= S_DONE;
              r_timeout <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_pass  <= r_pass + 8'd1;
              r_gof   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.go) begin
            r_state   <= S_FILL;
            r_addr    <= '0;
            r_pass    <= '0;
            r_timeout <= 1'b0;
            r_gow     <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_addr  <= '0;
        end
      endcase
    end
  end

  assign bus.go_whitening = r_gow;
  assign bus.go_fastica   = r_gof;
  assign bus.mem_rw       = (r_state == S_FILL);
  assign bus.mem_addr     = r_addr;
  assign bus.z_valid      = r_zv;
  assign bus.z_last       = r_zl;
  assign bus.pass_idx     = r_pass;
  assign bus.busy         = (r_state == S_FILL) ||
                            (r_state == S_READ) ||
                            (r_state == S_WAIT);
  assign bus.done         = (r_state == S_DONE);
  assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_ica_ram_sequencer.sv
// Directed bench for ica_ram_sequencer: N_SAMPLES=8 in a 3-bit address
// space, MAX_PASSES=4; vector table plus fill/pass/reset sequences.
module tb_ica_ram_sequencer;
  localparam int AW = 3;
  localparam int NS = 8;
  localparam int MP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ica_ram_sequencer_if #(.ADDR_W(AW)) bus();

  ica_ram_sequencer #(
    .ADDR_W(AW),
    .N_SAMPLES(NS),
    .MAX_PASSES(MP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic        go;
    logic        wv;
    logic        nx;
    logic        cv;
    logic [18:0] want;
  } vec_t;

  vec_t tbl [19];
  int   errs = 0;
  int   checks = 0;
  int   n_gof = 0;
  int   n_gow = 0;
  int   n_zv = 0;
  int   n_zl = 0;
  int   n_fill = 0;
  int   wr_q [$];

  function automatic logic [18:0] outs();
    return {bus.go_whitening, bus.go_fastica, bus.mem_rw,
            bus.mem_addr, bus.z_valid, bus.z_last, bus.pass_idx,
            bus.busy, bus.done, bus.timeout};
  endfunction

  function automatic logic [18:0] e(
    logic gow, logic gof, logic rw, logic [2:0] a,
    logic zv, logic zl, logic [7:0] p,
    logic b, logic d, logic t);
    return {gow, gof, rw, a, zv, zl, p, b, d, t};
  endfunction

  function automatic vec_t row(
    logic g, logic wv, logic nx, logic cv, logic [18:0] w);
    return {g, wv, nx, cv, w};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // Drive at negedge, record RAM writes at the edge, sample at next negedge
  task automatic step(input logic g, input logic wv,
                      input logic nx, input logic cv);
    bus.go            = g;
    bus.whiten_valid  = wv;
    bus.ica_next      = nx;
    bus.ica_converged = cv;
    if (bus.mem_rw && wv && rst_n) wr_q.push_back(int'(bus.mem_addr));
    @(posedge clk);
    @(negedge clk);
    if (bus.go_fastica)   n_gof++;
    if (bus.go_whitening) n_gow++;
    if (bus.z_valid)      n_zv++;
    if (bus.z_last)       n_zl++;
    if (bus.busy && bus.mem_rw) n_fill++;
  endtask

  initial begin
    bus.go = 1'b0;
    bus.whiten_valid = 1'b0;
    bus.ica_next = 1'b0;
    bus.ica_converged = 1'b0;

    tbl[0] = row(1, 0, 0, 0, e(1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 1; i < 8; i++)
      tbl[i] = row(0, 1, 0, 0, e(0, 0, 1, 3'(i), 0, 0, 0, 1, 0, 0));
    tbl[8]  = row(0, 1, 0, 0, e(0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl[9]  = row(0, 1, 0, 0, e(0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    tbl[10] = row(1, 0, 0, 0, e(0, 0, 0, 2, 1, 0, 0, 1, 0, 0));
    tbl[11] = row(0, 0, 0, 0, e(0, 0, 0, 3, 1, 0, 0, 1, 0, 0));
    tbl[12] = row(0, 0, 1, 0, e(0, 0, 0, 4, 1, 0, 0, 1, 0, 0));
    tbl[13] = row(0, 0, 0, 1, e(0, 0, 0, 5, 1, 0, 0, 1, 0, 0));
    tbl[14] = row(0, 0, 0, 0, e(0, 0, 0, 6, 1, 0, 0, 1, 0, 0));
    tbl[15] = row(0, 0, 0, 0, e(0, 0, 0, 7, 1, 0, 0, 1, 0, 0));
    tbl[16] = row(0, 0, 0, 0, e(0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
    tbl[17] = row(1, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl[18] = row(0, 0, 1, 0, e(0, 1, 0, 0, 0, 0, 1, 1, 0, 0));

    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", 32'(outs()), 32'd0);

    // Continuous fill, pass 0 with ignored go/next/converged
    wr_q.delete();
    n_gof = 0;
    n_zv = 0;
    n_zl = 0;
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].go, tbl[i].wv, tbl[i].nx, tbl[i].cv);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].want));
    end
    chk("fill_nwrites", wr_q.size(), NS);
    for (int i = 0; i < wr_q.size(); i++)
      chk($sformatf("fill_waddr%0d", i), wr_q[i], i);
    chk("pass0_zv", n_zv, NS);
    chk("pass0_zl", n_zl, 1);

    // Passes 1..3 ending on the pass limit
    for (int p = 1; p < MP; p++) begin
      n_zv = 0;
      n_zl = 0;
      repeat (NS - 1) step(0, 0, 0, 0);
      chk($sformatf("pass%0d_zl_early", p), n_zl, 0);
      step(0, 0, 0, 0);
      chk($sformatf("pass%0d_zv", p), n_zv, NS);
      chk($sformatf("pass%0d_wait", p), 32'(outs()),
          32'(e(0, 0, 0, 0, 1, 1, 8'(p), 1, 0, 0)));
      step(0, 0, 1, 0);
    end
    chk("timeout_done", 32'(outs()),
        32'(e(0, 0, 0, 0, 0, 0, 3, 0, 1, 1)));
    chk("timeout_ngof", n_gof, MP);
    step(0, 1, 1, 1);
    chk("done_hold", 32'(outs()),
        32'(e(0, 0, 0, 0, 0, 0, 3, 0, 1, 1)));

    // Restart from DONE with a stalling fill
    step(1, 0, 0, 0);
    chk("restart", 32'(outs()),
        32'(e(1, 0, 1, 0, 0, 0, 0, 1, 0, 0)));
    wr_q.delete();
    n_fill = 1;
    for (int k = 0; k < 15; k++) begin
      step(0, logic'(k % 2 == 0), 0, 0);
      if (k == 13)
        chk("stall_addr7", 32'(bus.mem_addr), 32'd7);
    end
    chk("stall_read", 32'(outs()),
        32'(e(0, 1, 0, 0, 0, 0, 0, 1, 0, 0)));
    chk("stall_fill_len", n_fill, 15);
    chk("stall_nwrites", wr_q.size(), NS);
    for (int i = 0; i < wr_q.size(); i++)
      chk($sformatf("stall_waddr%0d", i), wr_q[i], i);

    // Converged and next together in pass 1; go during READ ignored
    n_gow = 0;
    for (int k = 0; k < NS; k++) step(logic'(k == 2), 0, 0, 0);
    step(0, 0, 1, 0);
    chk("p1_start", 32'(outs()),
        32'(e(0, 1, 0, 0, 0, 0, 1, 1, 0, 0)));
    repeat (3) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("go_in_read", 32'(outs()),
        32'(e(0, 0, 0, 4, 1, 0, 1, 1, 0, 0)));
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    chk("conv_done", 32'(outs()),
        32'(e(0, 0, 0, 0, 0, 0, 1, 0, 1, 0)));
    chk("busy_ngow", n_gow, 0);

    // Asynchronous reset mid-fill at addr 5
    step(1, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    chk("pre_rst_addr", 32'(outs()),
        32'(e(0, 0, 1, 5, 0, 0, 0, 1, 0, 0)));
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 32'(outs()), 32'd0);
    wr_q.delete();
    @(negedge clk);
    step(0, 1, 0, 0);
    chk("rst_no_write", wr_q.size(), 0);
    chk("rst_hold", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    chk("rst_restart", 32'(outs()),
        32'(e(1, 0, 1, 0, 0, 0, 0, 1, 0, 0)));
    step(0, 1, 0, 0);
    chk("rst_addr1", 32'(bus.mem_addr), 32'd1);
    chk("rst_waddr0", wr_q.size() == 1 ? wr_q[0] : -1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
